stage_wb_multi: RTL and testbench
=================================

// Module: stage_wb_multi
// PURPOSE
//  Multi-lane writeback stage for the wide-issue pipeline: accepts a bundle of LANES results from MEM
//  and retires them to a register file with RF_PORTS write ports, serialising over several cycles when
//  LANES > RF_PORTS. Also exposes per-lane forwarding to ID, a flush, and a retired-instruction counter.
// PARAMETERS
//  LANES     2   result lanes per bundle (>=1)
//  RF_PORTS  1   register-file write ports (1..LANES)
//  DATA_W    32  result width
//  ADDR_W    5   register address width; address 0 is never written
//  PC_W      32  PC width, held for trace
// PORTS
//  clk          in   1               clock
//  rst          in   1               reset: synchronous, active-high
//  validin      in   1               upstream bundle valid
//  allowin      out  1               stage can accept a bundle this cycle
//  validout     out  1               bundle completely retired, presented to trace
//  allowout     in   1               trace side accepts
//  flush        in   1               discard held bundle (synchronous)
//  in_lane_vld  in   LANES           lane holds a real instruction
//  in_pc        in   LANES*PC_W      per-lane PC (lane i at [i*PC_W +: PC_W])
//  in_rf_we     in   LANES           lane writes a register
//  in_rf_waddr  in   LANES*ADDR_W    per-lane destination
//  in_rf_wdata  in   LANES*DATA_W    per-lane result
//  rf_we        out  RF_PORTS        RF write enables
//  rf_waddr     out  RF_PORTS*ADDR_W RF write addresses
//  rf_wdata     out  RF_PORTS*DATA_W RF write data
//  out_pc       out  LANES*PC_W      held PCs (trace)
//  out_lane_vld out  LANES           held lane valids (trace)
//  fwd_we       out  LANES           lane i forwarding entry live
//  fwd_addr     out  LANES*ADDR_W    lane i destination
//  fwd_data     out  LANES*DATA_W    lane i result
//  retire_cnt   out  32              count of retired valid lanes
// BEHAVIOUR
//  - Accept on edge where validin && allowin: latch all in_* into holding regs, set valid,
//    pending[i] = in_lane_vld[i] & in_rf_we[i] & (in_rf_waddr[i] != 0).
//  - States: EMPTY (valid=0) / DRAIN (valid=1, pending!=0) / DONE (valid=1, pending==0).
//  - Each cycle in DRAIN: issue group = lowest-index set bits of pending, at most RF_PORTS;
//    port k carries the k-th lane of the group, ascending lane order; unused ports rf_we=0.
//    rf_* are combinational from holding regs + pending; issued bits clear at the next edge.
//  - Same waddr on two lanes of one group: lower lane's port forced rf_we=0 (higher lane wins).
//    Across groups, lane order already gives later-lane-wins.
//  - done = valid && (pending & ~issue_group)==0; validout = done; DRAIN->DONE at the issue edge.
//  - Writes take ceil(P/RF_PORTS) cycles, P = popcount(pending at accept); P=0 -> DONE on arrival,
//    validout in the first cycle, no rf_we.
//  - allowin = !valid || (done && allowout): back-to-back bundles, no bubble at completion.
//  - DONE with allowout=0: hold, validout stays 1, rf_we=0 (no rewrites).
//  - retire_cnt += popcount(out_lane_vld) on each edge with validout && allowout; wraps mod 2^32.
//  - fwd_we[i] = valid & lane_vld[i] & we[i] & (waddr[i]!=0), independent of pending; data is final
//    so consumers always treat it as ready. Multiple matches: highest lane wins (consumer rule).
//  - flush: in that cycle rf_we=0, validout=0, fwd_we=0; next edge valid<=0, pending<=0,
//    retire_cnt unchanged; a same-cycle validin is dropped (allowin forced 0 while flush=1).
//  - Reset: valid=0, pending=0, retire_cnt=0, all holding regs 0 -> every output 0, except allowin=1.
//    Reset mid-drain abandons remaining writes.
// TESTING
//  1 LANES=2,RF_PORTS=1: bundle {r5=0x11, r6=0x22} -> c0 port0 r5/0x11, c1 r6/0x22, validout only in c1.
//  2 lane0 waddr=0 we=1, lane1 r6=0x22 -> single cycle: r6 written, validout in c0, retire_cnt+=2.
//  3 RF_PORTS=2, both lanes r7 (0xA,0xB) -> one cycle: port0 we=0, port1 r7/0xB.
//  4 allowout=0 at done for 3 cycles -> validout held 1, rf_we=0, allowin=0; new bundle accepted on release.
//  5 flush in c1 of test 1 (after r5 written) -> r6 never written, allowin=1 next cycle, retire_cnt unchanged.
//  6 retire_cnt preloaded 0xFFFFFFFF via 2^32-1 retirements (force) + 2-lane retire -> 0x00000001.

Source files
------------

// File: rtl/stage_wb_multi_if.sv
// Bundle/handshake bundle between MEM, the writeback stage, the register file, ID forwarding and trace.
interface stage_wb_multi_if #(
    parameter int LANES    = 2,
    parameter int RF_PORTS = 1,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int PC_W     = 32
);
    logic                       validin;
    logic                       allowin;
    logic                       validout;
    logic                       allowout;
    logic                       flush;
    logic [LANES-1:0]           in_lane_vld;
    logic [LANES*PC_W-1:0]      in_pc;
    logic [LANES-1:0]           in_rf_we;
    logic [LANES*ADDR_W-1:0]    in_rf_waddr;
    logic [LANES*DATA_W-1:0]    in_rf_wdata;
    logic [RF_PORTS-1:0]        rf_we;
    logic [RF_PORTS*ADDR_W-1:0] rf_waddr;
    logic [RF_PORTS*DATA_W-1:0] rf_wdata;
    logic [LANES*PC_W-1:0]      out_pc;
    logic [LANES-1:0]           out_lane_vld;
    logic [LANES-1:0]           fwd_we;
    logic [LANES*ADDR_W-1:0]    fwd_addr;
    logic [LANES*DATA_W-1:0]    fwd_data;
    logic [31:0]                retire_cnt;

    modport master (
        output validin, allowout, flush, in_lane_vld, in_pc, in_rf_we, in_rf_waddr, in_rf_wdata,
        input  allowin, validout, rf_we, rf_waddr, rf_wdata, out_pc, out_lane_vld,
               fwd_we, fwd_addr, fwd_data, retire_cnt
    );

    modport slave (
        input  validin, allowout, flush, in_lane_vld, in_pc, in_rf_we, in_rf_waddr, in_rf_wdata,
        output allowin, validout, rf_we, rf_waddr, rf_wdata, out_pc, out_lane_vld,
               fwd_we, fwd_addr, fwd_data, retire_cnt
    );
endinterface

// File: rtl/stage_wb_multi.sv
// Multi-lane writeback: holds one bundle and retires its register writes over as many cycles as
// the RF write ports require, with forwarding, flush and a retired-lane counter.
//
// state | meaning
// EMPTY | no bundle held
// DRAIN | bundle held, register writes still pending
// DONE  | bundle held, all writes issued, waiting for trace to accept
module stage_wb_multi #(
    parameter int LANES    = 2,
    parameter int RF_PORTS = 1,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int PC_W     = 32
) (
    input logic             clk,
    input logic             rst,
    stage_wb_multi_if.slave bus
);
    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [LANES-1:0]    lane_vld_q;
    logic [LANES-1:0]    we_q;
    logic [LANES-1:0]    pending_q;
    logic [PC_W-1:0]     pc_q    [LANES];
    logic [ADDR_W-1:0]   waddr_q [LANES];
    logic [DATA_W-1:0]   wdata_q [LANES];
    logic [31:0]         cnt_q;

    logic [LANES-1:0]    new_pending;
    logic [LANES-1:0]    grp;
    logic [RF_PORTS-1:0] port_used;
    logic [RF_PORTS-1:0] port_kill;
    logic [LIW-1:0]      port_lane [RF_PORTS];
    int                  rank;
    logic                valid;
    logic                done;
    logic                accept;
    logic                retire;

    function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
        popcount = '0;
        for (int i = 0; i < LANES; i++) popcount = popcount + 32'(v[i]);
    endfunction

    assign valid  = (state != EMPTY);
    assign done   = valid && ((pending_q & ~grp) == '0);
    assign retire = bus.validout && bus.allowout;
    assign accept = bus.validin && bus.allowin;

    assign bus.validout     = done && !bus.flush;
    assign bus.allowin      = !bus.flush && (!valid || (done && bus.allowout));
    assign bus.out_lane_vld = lane_vld_q;
    assign bus.retire_cnt   = cnt_q;

    // Issue group: the lowest-index pending lanes, at most RF_PORTS of them, in ascending order.
    always_comb begin
        grp       = '0;
        port_used = '0;
        rank      = 0;
        for (int k = 0; k < RF_PORTS; k++) port_lane[k] = '0;
        for (int i = 0; i < LANES; i++) begin
            rank = 0;
            for (int j = 0; j < i; j++) rank = rank + int'(pending_q[j]);
            if (pending_q[i] && rank < RF_PORTS) begin
                grp[i] = 1'b1;
                for (int k = 0; k < RF_PORTS; k++) begin
                    if (rank == k) begin
                        port_used[k] = 1'b1;
                        port_lane[k] = LIW'(i);
                    end
                end
            end
        end
    end

    // A later port in the same group carries a higher lane, so it wins a same-address clash.
    always_comb begin
        port_kill = '0;
        for (int k = 0; k < RF_PORTS; k++) begin
            for (int j = k + 1; j < RF_PORTS; j++) begin
                if (port_used[j] && (waddr_q[port_lane[j]] == waddr_q[port_lane[k]]))
                    port_kill[k] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < RF_PORTS; k++) begin : g_port
        assign bus.rf_we[k] = (state == DRAIN) && !bus.flush && port_used[k] && !port_kill[k];
        assign bus.rf_waddr[k*ADDR_W +: ADDR_W] = waddr_q[port_lane[k]];
        assign bus.rf_wdata[k*DATA_W +: DATA_W] = wdata_q[port_lane[k]];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign new_pending[i] = bus.in_lane_vld[i] & bus.in_rf_we[i]
                              & (bus.in_rf_waddr[i*ADDR_W +: ADDR_W] != '0);
        assign bus.fwd_we[i]  = valid & !bus.flush & lane_vld_q[i] & we_q[i] & (waddr_q[i] != '0);
        assign bus.fwd_addr[i*ADDR_W +: ADDR_W] = waddr_q[i];
        assign bus.fwd_data[i*DATA_W +: DATA_W] = wdata_q[i];
        assign bus.out_pc[i*PC_W +: PC_W]       = pc_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            pending_q  <= '0;
            lane_vld_q <= '0;
            we_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < LANES; i++) begin
                pc_q[i]    <= '0;
                waddr_q[i] <= '0;
                wdata_q[i] <= '0;
            end
        end else if (bus.flush) begin
            state     <= EMPTY;
            pending_q <= '0;
        end else begin
            if (retire) cnt_q <= cnt_q + popcount(lane_vld_q);
            if (accept) begin
                state      <= (new_pending != '0) ? DRAIN : DONE;
                pending_q  <= new_pending;
                lane_vld_q <= bus.in_lane_vld;
                we_q       <= bus.in_rf_we;
                for (int i = 0; i < LANES; i++) begin
                    pc_q[i]    <= bus.in_pc[i*PC_W +: PC_W];
                    waddr_q[i] <= bus.in_rf_waddr[i*ADDR_W +: ADDR_W];
                    wdata_q[i] <= bus.in_rf_wdata[i*DATA_W +: DATA_W];
                end
            end else if (retire) begin
                state     <= EMPTY;
                pending_q <= '0;
            end else if (state == DRAIN) begin
                pending_q <= pending_q & ~grp;
                if (done) state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_stage_wb_multi.sv
// Directed bench for stage_wb_multi: one instance with a single RF port, one with two.
module tb_stage_wb_multi;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_wb_multi_if #(.LANES(2), .RF_PORTS(1), .DATA_W(32), .ADDR_W(5), .PC_W(32)) i1 ();
    stage_wb_multi_if #(.LANES(2), .RF_PORTS(2), .DATA_W(32), .ADDR_W(5), .PC_W(32)) i2 ();

    stage_wb_multi #(.LANES(2), .RF_PORTS(1), .DATA_W(32), .ADDR_W(5), .PC_W(32))
        u_d1 (.clk(clk), .rst(rst), .bus(i1));
    stage_wb_multi #(.LANES(2), .RF_PORTS(2), .DATA_W(32), .ADDR_W(5), .PC_W(32))
        u_d2 (.clk(clk), .rst(rst), .bus(i2));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [1:0] vld, input logic [1:0] we, input logic [4:0] a1,
                         input logic [4:0] a0, input logic [31:0] d1, input logic [31:0] d0);
        i1.validin     = 1'b1;
        i1.in_lane_vld = vld;
        i1.in_rf_we    = we;
        i1.in_rf_waddr = {a1, a0};
        i1.in_rf_wdata = {d1, d0};
        i1.in_pc       = {32'h0000_1004, 32'h0000_1000};
    endtask

    task automatic load2(input logic [1:0] vld, input logic [1:0] we, input logic [4:0] a1,
                         input logic [4:0] a0, input logic [31:0] d1, input logic [31:0] d0);
        i2.validin     = 1'b1;
        i2.in_lane_vld = vld;
        i2.in_rf_we    = we;
        i2.in_rf_waddr = {a1, a0};
        i2.in_rf_wdata = {d1, d0};
        i2.in_pc       = {32'h0000_2004, 32'h0000_2000};
    endtask

    initial begin
        i1.validin = 1'b0; i1.allowout = 1'b1; i1.flush = 1'b0;
        i1.in_lane_vld = '0; i1.in_rf_we = '0; i1.in_rf_waddr = '0; i1.in_rf_wdata = '0; i1.in_pc = '0;
        i2.validin = 1'b0; i2.allowout = 1'b1; i2.flush = 1'b0;
        i2.in_lane_vld = '0; i2.in_rf_we = '0; i2.in_rf_waddr = '0; i2.in_rf_wdata = '0; i2.in_pc = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // reset state
        check("rst_allowin",  i1.allowin, 1);
        check("rst_validout", i1.validout, 0);
        check("rst_rf_we",    i1.rf_we, 0);
        check("rst_cnt",      i1.retire_cnt, 0);
        check("rst_fwd_we",   i1.fwd_we, 0);
        check("rst_out_pc",   i1.out_pc, 0);
        check("rst_lane_vld", i1.out_lane_vld, 0);
        check("rst_allowin2", i2.allowin, 1);

        // two lanes through one port: r5 then r6
        load1(2'b11, 2'b11, 5'd6, 5'd5, 32'h22, 32'h11);
        #1 check("t1_allowin", i1.allowin, 1);
        cyc(); i1.validin = 1'b0; #1;
        check("t1_c0_we",    i1.rf_we, 1);
        check("t1_c0_addr",  i1.rf_waddr, 5);
        check("t1_c0_data",  i1.rf_wdata, 32'h11);
        check("t1_c0_vout",  i1.validout, 0);
        check("t1_c0_allow", i1.allowin, 0);
        check("t1_c0_fwd",   i1.fwd_we, 2'b11);
        check("t1_c0_pc",    i1.out_pc, {32'h0000_1004, 32'h0000_1000});
        cyc(); #1;
        check("t1_c1_we",    i1.rf_we, 1);
        check("t1_c1_addr",  i1.rf_waddr, 6);
        check("t1_c1_data",  i1.rf_wdata, 32'h22);
        check("t1_c1_vout",  i1.validout, 1);
        check("t1_c1_allow", i1.allowin, 1);
        cyc(); #1;
        check("t1_end_vout", i1.validout, 0);
        check("t1_end_we",   i1.rf_we, 0);
        check("t1_end_cnt",  i1.retire_cnt, 2);

        // lane0 targets r0: only r6 written, done in first cycle
        load1(2'b11, 2'b11, 5'd6, 5'd0, 32'h22, 32'h55);
        cyc(); i1.validin = 1'b0; #1;
        check("t2_we",    i1.rf_we, 1);
        check("t2_addr",  i1.rf_waddr, 6);
        check("t2_data",  i1.rf_wdata, 32'h22);
        check("t2_vout",  i1.validout, 1);
        check("t2_fwd",   i1.fwd_we, 2'b10);
        check("t2_faddr", i1.fwd_addr[9:5], 6);
        cyc(); #1;
        check("t2_cnt",   i1.retire_cnt, 4);

        // two ports, both lanes r7: lower port suppressed
        load2(2'b11, 2'b11, 5'd7, 5'd7, 32'hB, 32'hA);
        cyc(); i2.validin = 1'b0; #1;
        check("t3_we",    i2.rf_we, 2'b10);
        check("t3_addr1", i2.rf_waddr[9:5], 7);
        check("t3_data1", i2.rf_wdata[63:32], 32'hB);
        check("t3_vout",  i2.validout, 1);
        cyc(); #1;
        check("t3_cnt",   i2.retire_cnt, 2);

        // nothing to write: done on arrival
        load2(2'b11, 2'b00, 5'd3, 5'd4, 32'h1, 32'h2);
        cyc(); i2.validin = 1'b0; #1;
        check("p0_we",    i2.rf_we, 0);
        check("p0_vout",  i2.validout, 1);
        check("p0_allow", i2.allowin, 1);
        cyc(); #1;
        check("p0_cnt",   i2.retire_cnt, 4);

        // trace back-pressure for three cycles after completion
        i1.allowout = 1'b0;
        load1(2'b11, 2'b11, 5'd6, 5'd5, 32'h22, 32'h11);
        cyc(); i1.validin = 1'b0; #1;
        check("t4_c0_addr", i1.rf_waddr, 5);
        cyc(); #1;
        check("t4_c1_addr",  i1.rf_waddr, 6);
        check("t4_c1_vout",  i1.validout, 1);
        check("t4_c1_allow", i1.allowin, 0);
        for (int n = 0; n < 3; n++) begin
            cyc();
            if (n == 0) load1(2'b01, 2'b01, 5'd9, 5'd8, 32'h44, 32'h33);
            #1;
            check("t4_hold_vout",  i1.validout, 1);
            check("t4_hold_we",    i1.rf_we, 0);
            check("t4_hold_allow", i1.allowin, 0);
        end
        i1.allowout = 1'b1;
        #1 check("t4_rel_allow", i1.allowin, 1);
        cyc(); i1.validin = 1'b0; #1;
        check("t4_new_we",   i1.rf_we, 1);
        check("t4_new_addr", i1.rf_waddr, 8);
        check("t4_new_data", i1.rf_wdata, 32'h33);
        check("t4_new_vout", i1.validout, 1);
        check("t4_new_lvld", i1.out_lane_vld, 2'b01);
        check("t4_cnt_a",    i1.retire_cnt, 6);
        cyc(); #1;
        check("t4_cnt_b",    i1.retire_cnt, 7);

        // flush after the first write; a same-cycle bundle is dropped
        load1(2'b11, 2'b11, 5'd6, 5'd5, 32'h22, 32'h11);
        cyc(); i1.validin = 1'b0; #1;
        check("t5_c0_we", i1.rf_we, 1);
        cyc();
        i1.flush = 1'b1;
        load1(2'b11, 2'b11, 5'd10, 5'd9, 32'h66, 32'h77);
        #1;
        check("t5_fl_we",    i1.rf_we, 0);
        check("t5_fl_vout",  i1.validout, 0);
        check("t5_fl_allow", i1.allowin, 0);
        check("t5_fl_fwd",   i1.fwd_we, 0);
        cyc(); i1.flush = 1'b0; i1.validin = 1'b0; #1;
        check("t5_allow", i1.allowin, 1);
        check("t5_vout",  i1.validout, 0);
        check("t5_we",    i1.rf_we, 0);
        check("t5_cnt",   i1.retire_cnt, 7);
        cyc(); #1;
        check("t5_drop_we", i1.rf_we, 0);

        // counter wrap
        force u_d1.cnt_q = 32'hFFFF_FFFF;
        cyc();
        release u_d1.cnt_q;
        #1 check("t6_pre", i1.retire_cnt, 32'hFFFF_FFFF);
        load1(2'b11, 2'b11, 5'd6, 5'd5, 32'h22, 32'h11);
        cyc(); i1.validin = 1'b0;
        cyc(); #1;
        check("t6_vout", i1.validout, 1);
        cyc(); #1;
        check("t6_wrap", i1.retire_cnt, 32'h0000_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
